seg_scan_mux: RTL

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a three-digit, seven-segment display.
// Each frame latches seg0..seg2 into a shadow, so the three digits always show
// one consistent value. The frame then shows each digit for DWELL cycles on a
// shared segment bus, with a one-hot digit enable.
// Optional feature macro: SEG_SCAN_BLANK_EN. When it is defined, the block adds
// an anti-ghosting blank of BLANK cycles after every digit.
// Handshake: there is none. en is a level-sensitive qualifier. A cycle with
// en=0 freezes the scan position and blanks the outputs for that cycle.
// dbg_state exposes {phase, idx} so that checkers can follow the scan position.
module seg_scan_mux #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    output logic [7:0] seg_out,
    output logic [2:0] dig_en,
    output logic       frame_start,
    output logic [2:0] dbg_state
);

    localparam logic [0:0] SHOW = 1'b0;
    localparam logic [0:0] BLNK = 1'b1;
    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    // Reject illegal parameter values when the design is elaborated.
    if (DWELL < 1 || DWELL > 65535) begin : g_dwell_chk
        $error("seg_scan_mux: DWELL out of range");
    end
    if (BLANK < 1 || BLANK > 255) begin : g_blank_chk
        $error("seg_scan_mux: BLANK out of range");
    end

    logic [1:0]  idx;
    logic [15:0] cnt;
    logic [0:0]  phase;
    logic [7:0]  shadow0, shadow1, shadow2;
    logic [7:0]  cur_seg;
    logic [1:0]  idx_next;
    logic        frame_load;

    // Select the shadow byte for the current digit, and the next digit index.
    always_comb begin
        cur_seg  = shadow0;
        idx_next = 2'd0;
        case (idx)
            2'd0:    begin cur_seg = shadow0; idx_next = 2'd1; end
            2'd1:    begin cur_seg = shadow1; idx_next = 2'd2; end
            2'd2:    begin cur_seg = shadow2; idx_next = 2'd0; end
            default: begin cur_seg = shadow0; idx_next = 2'd0; end
        endcase
    end

    // A frame starts on the first cycle of the ones digit.
    assign frame_load = (phase == SHOW) && (idx == 2'd0) && (cnt == 16'd0);
    assign dbg_state  = {phase, idx};

`ifdef SEG_SCAN_BLANK_EN
    logic [7:0] bcnt;
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);

    // Scan engine with a blank phase after every digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out     <= 8'h00;
            dig_en      <= 3'b000;
            frame_start <= 1'b0;
            shadow0     <= 8'h00;
            shadow1     <= 8'h00;
            shadow2     <= 8'h00;
            idx         <= 2'd0;
            cnt         <= 16'd0;
            phase       <= SHOW;
            bcnt        <= 8'd0;
        end else if (!en) begin
            seg_out     <= 8'h00;
            dig_en      <= 3'b000;
            frame_start <= 1'b0;
        end else if (phase == SHOW) begin
            if (frame_load) begin
                shadow0     <= seg0;
                shadow1     <= seg1;
                shadow2     <= seg2;
                seg_out     <= seg0;
                frame_start <= 1'b1;
            end else begin
                seg_out     <= cur_seg;
                frame_start <= 1'b0;
            end
            dig_en <= 3'(3'b001 << idx);
            if (cnt == DWELL_LAST) begin
                cnt   <= 16'd0;
                phase <= BLNK;
                bcnt  <= 8'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end else begin
            seg_out     <= 8'h00;
            dig_en      <= 3'b000;
            frame_start <= 1'b0;
            if (bcnt == BLANK_LAST) begin
                bcnt  <= 8'd0;
                phase <= SHOW;
                idx   <= idx_next;
            end else begin
                bcnt <= bcnt + 8'd1;
            end
        end
    end
`else
    assign phase = SHOW;

    // Scan engine without blanking: every digit follows the previous one directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out     <= 8'h00;
            dig_en      <= 3'b000;
            frame_start <= 1'b0;
            shadow0     <= 8'h00;
            shadow1     <= 8'h00;
            shadow2     <= 8'h00;
            idx         <= 2'd0;
            cnt         <= 16'd0;
        end else if (!en) begin
            seg_out     <= 8'h00;
            dig_en      <= 3'b000;
            frame_start <= 1'b0;
        end else begin
            if (frame_load) begin
                shadow0     <= seg0;
                shadow1     <= seg1;
                shadow2     <= seg2;
                seg_out     <= seg0;
                frame_start <= 1'b1;
            end else begin
                seg_out     <= cur_seg;
                frame_start <= 1'b0;
            end
            dig_en <= 3'(3'b001 << idx);
            if (cnt == DWELL_LAST) begin
                cnt <= 16'd0;
                idx <= idx_next;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
`endif

endmodule
